dram_read_streamer: RTL and testbench
=====================================

Name: dram_read_streamer

Overview:
- Downstream consumer of the PCIe command stage on the DRAM read path.
- Accepts one read command (base address, line count, slot) and issues pipelined 64-byte DRAM reads, up to MAX_OUTSTANDING in flight.
- Buffers the 512-bit responses and serializes each one into four 128-bit PCIe beats.
- Replaces the one-read-at-a-time return loop, so read throughput is no longer bound by DRAM round-trip latency.

Parameters:
PA_WIDTH, 32, physical address bits kept; upper address bits forced to 0.
MAX_OUTSTANDING, 4, line-buffer depth; caps reads issued but not yet fully sent to PCIe (power of 2, 2..16).
LINE_BYTES, 64, address increment per read; fixed, 512-bit line.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  64  byte address of first line; bits[5:0] ignored
cmd_lines  in  16  number of lines to read (0 allowed)
cmd_slot  in  16  PCIe slot stamped on every output beat
mem_req_valid  out  1  read request present
mem_req_addr  out  64  read address
mem_req_grant  in  1  request accepted this cycle
mem_resp_valid  in  1  response data present
mem_resp_data  in  512  response line
mem_resp_grant  out  1  response consumed this cycle
pcie_valid  out  1  beat present
pcie_data  out  128  beat payload
pcie_slot  out  16  latched cmd_slot
pcie_last  out  1  final beat of command
pcie_grant  in  1  beat consumed this cycle
busy  out  1  command in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - all outputs 0, including cmd_ready;
  - state=IDLE; counters, buffer pointers and beat index cleared; buffer contents don't-care.
- States: IDLE, STREAM, DRAIN.
- IDLE: cmd_ready=1.
  - On accept, latch addr = {0, cmd_addr[PA_WIDTH-1:6], 6'b0}, lines_to_issue = lines_to_send = cmd_lines, slot.
  - Go to STREAM; if cmd_lines==0, stay in IDLE (no requests, no beats).
- STREAM: cmd_ready=0.
  - Issue: mem_req_valid = (lines_to_issue != 0) && (inflight < MAX_OUTSTANDING).
    - inflight = reads issued minus lines fully sent to PCIe.
  - On mem_req_grant: addr += 64, wrapping modulo 2^PA_WIDTH (0xFFFFFFC0 -> 0x0); lines_to_issue--, inflight++.
  - mem_req_valid/addr stay stable until granted.
  - Response: mem_resp_grant = mem_resp_valid && buffer not full; line written at tail, tail++.
    - The credit rule guarantees the buffer is never full when a response arrives; the buffer-full check is defensive.
  - Output: pcie_valid = buffer not empty.
    - pcie_data = head line bits[128*beat+127 : 128*beat], beat 0 = bits[127:0].
  - On pcie_grant: beat++.
    - At beat 3: head++, inflight--, lines_to_send--, beat=0.
  - pcie_last = pcie_valid && beat==3 && lines_to_send==1.
  - When the last beat is granted: -> IDLE, with cmd_ready=1 the next cycle.
- Simultaneous events: issue grant and line retire in the same cycle leave inflight unchanged. Response write and head read in the same cycle are both legal.
- Latency:
  - cmd accept at cycle N -> mem_req_valid at N+1;
  - response accepted at M -> first pcie_valid at M+1 (registered buffer);
  - full rate is 4 beats per line once the buffer is non-empty.
- Backpressure: pcie_grant low stalls beats. Issue continues until inflight==MAX_OUTSTANDING, then stalls.
- Responses strictly in request order; no reordering supported.
- DRAIN (entered on asynchronous reset deassertion only if a fabric reset left responses pending is not tracked):
  - Not entered in normal operation; reserved encoding; behaves as IDLE.
  - Any mem_resp_valid seen while in IDLE is granted and discarded (drops stale responses after a mid-operation reset).
- Reset mid-operation: state, counters and buffer are cleared at once. Beats not yet sent are lost; no pcie_last is produced for the aborted command.

Test Plan:
- Single line: cmd addr 0x1000, lines=1, slot=0 -> one request at 0x1000; four beats equal to resp bits[127:0], [255:128], [383:256], [511:384]; pcie_last on beat 4 only; cmd_ready back 1 cycle after the last grant.
- Pipelining: lines=8, memory latency 20 cycles, pcie_grant always 1 -> 4 requests issued before the first response; 32 beats in address order; inflight never exceeds 4.
- Backpressure: lines=6, pcie_grant held 0 for 100 cycles -> exactly 4 requests granted, then mem_req_valid stays 0 until beats drain; all 24 beats correct after release.
- Wrap and masking: cmd_addr 0xABCD_FFFF_FFC0, lines=2 -> request addresses 0xFFFFFFC0 then 0x00000000.
- Zero length: lines=0 -> no mem_req_valid, no pcie_valid, cmd_ready stays 1; the next command is accepted normally.
- Reset mid-stream: rst_n low after 5 of 16 beats, then a stale response arrives in IDLE -> outputs 0 during reset; stale response granted and dropped; a new command streams correctly.

Source files
------------

// File: rtl/dram_read_streamer.sv
// DRAM read streamer: issues pipelined 64-byte line reads for one command and
// serializes each buffered 512-bit response into four 128-bit PCIe beats.
module dram_read_streamer #(
  parameter int PA_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_BYTES      = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [15:0]  cmd_lines,
  input  logic [15:0]  cmd_slot,
  output logic         mem_req_valid,
  output logic [63:0]  mem_req_addr,
  input  logic         mem_req_grant,
  input  logic         mem_resp_valid,
  input  logic [511:0] mem_resp_data,
  output logic         mem_resp_grant,
  output logic         pcie_valid,
  output logic [127:0] pcie_data,
  output logic [15:0]  pcie_slot,
  output logic         pcie_last,
  input  logic         pcie_grant,
  output logic         busy
);

  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PA_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]         issue_q, issue_d;
  logic [15:0]         send_q, send_d;
  logic [15:0]         slot_q, slot_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    head_q, head_d;
  logic [CNT_W-1:0]    tail_q, tail_d;
  logic [1:0]          beat_q, beat_d;

  logic [511:0] line_mem [MAX_OUTSTANDING];
  logic [511:0] head_line;

  logic streaming, buf_empty, buf_full;
  logic cmd_fire, req_fire, wr_fire, beat_fire, line_done;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmd_addr[63:PA_WIDTH], cmd_addr[OFS_W-1:0]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    streaming = (state_q == ST_STREAM);
    buf_empty = (head_q == tail_q);
    buf_full  = (head_q[PTR_W] != tail_q[PTR_W]) &&
                (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
    head_line = line_mem[head_q[PTR_W-1:0]];

    // Outputs are gated by rst_n so they read 0 the instant reset asserts.
    cmd_ready      = rst_n && !streaming;
    mem_req_valid  = streaming && (issue_q != 16'd0) &&
                     (inflight_q < CNT_W'(MAX_OUTSTANDING));
    mem_req_addr   = 64'(addr_q);
    mem_resp_grant = rst_n && mem_resp_valid && (!streaming || !buf_full);
    pcie_valid     = streaming && !buf_empty;
    pcie_data      = pcie_valid ? head_line[{beat_q, 7'b0} +: 128] : 128'd0;
    pcie_slot      = slot_q;
    pcie_last      = pcie_valid && (beat_q == 2'd3) && (send_q == 16'd1);
    busy           = (state_q != ST_IDLE);

    cmd_fire  = cmd_valid && cmd_ready;
    req_fire  = mem_req_valid && mem_req_grant;
    wr_fire   = streaming && mem_resp_grant;
    beat_fire = pcie_valid && pcie_grant;
    line_done = beat_fire && (beat_q == 2'd3);
  end

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    send_d     = send_q;
    slot_d     = slot_q;
    inflight_d = inflight_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_d     = beat_q;

    if (streaming) begin
      if (line_done && (send_q == 16'd1)) state_d = ST_IDLE;
    end else begin
      // IDLE and the reserved DRAIN encoding both accept commands.
      state_d = ST_IDLE;
      if (cmd_fire) begin
        addr_d  = {cmd_addr[PA_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
        issue_d = cmd_lines;
        send_d  = cmd_lines;
        slot_d  = cmd_slot;
        if (cmd_lines != 16'd0) state_d = ST_STREAM;
      end
    end

    if (req_fire) begin
      addr_d  = addr_q + PA_WIDTH'(LINE_BYTES);
      issue_d = issue_q - 16'd1;
    end

    case ({req_fire, line_done})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (wr_fire) tail_d = tail_q + CNT_W'(1);

    if (beat_fire) beat_d = beat_q + 2'd1;
    if (line_done) begin
      head_d = head_q + CNT_W'(1);
      send_d = send_q - 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      send_q     <= '0;
      slot_q     <= '0;
      inflight_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      send_q     <= send_d;
      slot_q     <= slot_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
    end
  end

  // NOTE: the line buffer has no reset; cleared pointers make its contents
  // unobservable, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) line_mem[tail_q[PTR_W-1:0]] <= mem_resp_data;
  end

endmodule

// File: tb/tb_dram_read_streamer.sv
// Randomized bench for dram_read_streamer: a queue-based command/memory model
// predicts requests, grants and beats, and every cycle is compared against it.
module tb_dram_read_streamer;

  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [63:0]  cmd_addr = '0;
  logic [15:0]  cmd_lines = '0;
  logic [15:0]  cmd_slot = '0;
  logic         mem_req_valid;
  logic [63:0]  mem_req_addr;
  logic         mem_req_grant = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [511:0] mem_resp_data = '0;
  logic         mem_resp_grant;
  logic         pcie_valid;
  logic [127:0] pcie_data;
  logic [15:0]  pcie_slot;
  logic         pcie_last;
  logic         pcie_grant = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  dram_read_streamer #(.PA_WIDTH(32), .MAX_OUTSTANDING(MAX), .LINE_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_lines(cmd_lines), .cmd_slot(cmd_slot),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_grant(mem_req_grant),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant),
    .pcie_valid(pcie_valid), .pcie_data(pcie_data), .pcie_slot(pcie_slot),
    .pcie_last(pcie_last), .pcie_grant(pcie_grant), .busy(busy)
  );

  typedef struct packed { logic [127:0] data; logic last; } beat_t;
  typedef struct { logic [511:0] data; int ready; } resp_t;

  int checks = 0, failures = 0, cyc = 0;

  // Model state: pending request addresses, expected beats, the memory pipe.
  bit          model_idle = 1'b1;
  logic [31:0] exp_req[$];
  beat_t       exp_beats[$];
  resp_t       mem_q[$];
  int          inflight = 0, buffered = 0, beat_in_line = 0, last_ready = 0;
  logic [15:0] model_slot = '0;
  logic [31:0] salt = '0;

  bit          cmd_pending = 1'b0;
  logic [63:0] pend_addr = '0;
  logic [15:0] pend_lines = '0, pend_slot = '0;

  int mem_lat = 1, req_pct = 100, pcie_pct = 100, resp_pct = 100;
  bit pcie_hold = 1'b0, stale_inject = 1'b0, await_ready = 1'b0;
  logic ready_after_last = 1'b0;
  int req_fires = 0, beats_seen = 0, first_resp_reqs = -1;
  logic [127:0] obs_beats[$];
  logic [63:0]  obs_req[$];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [511:0] mem_line(input logic [31:0] a, input logic [31:0] s);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = a ^ (32'(k) * 32'h9E37_79B9) ^ s;
    return l;
  endfunction

  task automatic queue_cmd(input logic [63:0] a, input logic [15:0] n, input logic [15:0] s);
    pend_addr = a; pend_lines = n; pend_slot = s; cmd_pending = 1'b1;
  endtask

  task automatic model_reset();
    model_idle = 1'b1; exp_req.delete(); exp_beats.delete();
    inflight = 0; buffered = 0; beat_in_line = 0; cmd_pending = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    check1({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_req_valid"}, mem_req_valid, 1'b0);
    check128({tag, "_req_addr"}, 128'(mem_req_addr), 128'd0);
    check1({tag, "_resp_grant"}, mem_resp_grant, 1'b0);
    check1({tag, "_pcie_valid"}, pcie_valid, 1'b0);
    check128({tag, "_pcie_data"}, pcie_data, 128'd0);
    check128({tag, "_pcie_slot"}, 128'(pcie_slot), 128'd0);
    check1({tag, "_pcie_last"}, pcie_last, 1'b0);
  endtask

  // One clock: drive inputs at the falling edge, compare, then account for
  // the handshakes that the next rising edge will complete.
  task automatic step();
    bit req_fire, resp_fire, beat_fire, cmd_fire, exp_rv, was_last;
    logic [31:0] base, a;
    logic [511:0] line;
    resp_t r;
    @(negedge clk);
    cmd_valid = cmd_pending; cmd_addr = pend_addr; cmd_lines = pend_lines; cmd_slot = pend_slot;
    mem_req_grant = ($urandom_range(1, 100) <= req_pct);
    pcie_grant = !pcie_hold && ($urandom_range(1, 100) <= pcie_pct);
    if (stale_inject) begin
      mem_resp_valid = 1'b1; mem_resp_data = {16{32'hDEAD_BEEF}};
    end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(1, 100) <= resp_pct) begin
      mem_resp_valid = 1'b1; mem_resp_data = mem_q[0].data;
    end else begin
      mem_resp_valid = 1'b0; mem_resp_data = '0;
    end
    #1;
    if (await_ready) begin ready_after_last = cmd_ready; await_ready = 1'b0; end
    check1("cmd_ready", cmd_ready, model_idle);
    check1("busy", busy, !model_idle);
    exp_rv = !model_idle && exp_req.size() > 0 && inflight < MAX;
    check1("mem_req_valid", mem_req_valid, exp_rv);
    if (mem_req_valid && exp_req.size() > 0)
      check128("mem_req_addr", 128'(mem_req_addr), 128'({32'h0, exp_req[0]}));
    check1("pcie_valid", pcie_valid, !model_idle && buffered > 0);
    if (pcie_valid && exp_beats.size() > 0) begin
      check128("pcie_data", pcie_data, exp_beats[0].data);
      check128("pcie_slot", 128'(pcie_slot), 128'(model_slot));
      check1("pcie_last", pcie_last, exp_beats[0].last);
    end else begin
      check1("pcie_last_quiet", pcie_last, 1'b0);
    end
    check1("mem_resp_grant", mem_resp_grant, mem_resp_valid);

    cmd_fire  = cmd_valid && cmd_ready;
    req_fire  = mem_req_valid && mem_req_grant;
    resp_fire = mem_resp_valid && mem_resp_grant;
    beat_fire = pcie_valid && pcie_grant;

    if (req_fire && exp_req.size() > 0) begin
      r.data = mem_line(mem_req_addr[31:0], salt);
      last_ready = (cyc + mem_lat > last_ready) ? cyc + mem_lat : last_ready;
      r.ready = last_ready;
      mem_q.push_back(r);
      obs_req.push_back(mem_req_addr);
      void'(exp_req.pop_front());
      inflight++; req_fires++;
    end
    if (resp_fire) begin
      if (!stale_inject && mem_q.size() > 0) void'(mem_q.pop_front());
      if (!model_idle) begin
        buffered++;
        if (first_resp_reqs < 0) first_resp_reqs = req_fires;
      end
    end
    if (beat_fire && exp_beats.size() > 0) begin
      obs_beats.push_back(pcie_data);
      beats_seen++;
      was_last = exp_beats[0].last;
      void'(exp_beats.pop_front());
      beat_in_line++;
      if (beat_in_line == 4) begin beat_in_line = 0; inflight--; buffered--; end
      if (was_last) begin model_idle = 1'b1; await_ready = 1'b1; end
    end
    if (cmd_fire) begin
      cmd_pending = 1'b0;
      if (pend_lines != 16'd0) begin
        model_idle = 1'b0;
        model_slot = pend_slot;
        base = {pend_addr[31:6], 6'b0};
        for (int i = 0; i < int'(pend_lines); i++) begin
          a = base + 32'(i * 64);
          line = mem_line(a, salt);
          exp_req.push_back(a);
          for (int b = 0; b < 4; b++)
            exp_beats.push_back('{line[128*b +: 128], (i == int'(pend_lines) - 1) && (b == 3)});
        end
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((!model_idle || cmd_pending) && n < budget) begin step(); n++; end
    check1("done_in_budget", model_idle && !cmd_pending, 1'b1);
  endtask

  task automatic clear_obs();
    obs_beats.delete(); obs_req.delete();
    req_fires = 0; beats_seen = 0; first_resp_reqs = -1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    mem_resp_valid = 1'b1;
    #10 outputs_zero("reset");
    mem_resp_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single line at 0x1000.
    clear_obs(); salt = 32'h0; mem_lat = 5;
    queue_cmd(64'h1000, 16'd1, 16'h0);
    run_until_idle(200);
    step();
    check_int("t1_beats", obs_beats.size(), 4);
    check_int("t1_reqs", obs_req.size(), 1);
    if (obs_req.size() >= 1) check128("t1_req_addr", 128'(obs_req[0]), 128'h1000);
    if (obs_beats.size() >= 2) begin
      check128("t1_beat0_word0", 128'(obs_beats[0][31:0]), 128'h1000);
      check128("t1_beat1_word0", 128'(obs_beats[1][31:0]), 128'h78DD_F6E4);
    end
    check1("t1_ready_after_last", ready_after_last, 1'b1);

    // Pipelining: eight lines, 20-cycle memory latency.
    clear_obs(); salt = 32'h1111_2222; mem_lat = 20;
    queue_cmd(64'h0000_0000_0004_2000, 16'd8, 16'h00A5);
    run_until_idle(500);
    check_int("t2_reqs_before_resp", first_resp_reqs, 4);
    check_int("t2_beats", beats_seen, 32);

    // Backpressure: PCIe stalled for 100 cycles.
    clear_obs(); salt = 32'h3333_4444; mem_lat = 3; pcie_hold = 1'b1;
    queue_cmd(64'h8000, 16'd6, 16'h0BB0);
    repeat (100) step();
    check_int("t3_reqs_while_stalled", req_fires, 4);
    check1("t3_req_valid_stalled", mem_req_valid, 1'b0);
    pcie_hold = 1'b0;
    run_until_idle(500);
    check_int("t3_beats", beats_seen, 24);
    check_int("t3_reqs_total", req_fires, 6);

    // Address wrap and upper-bit masking.
    clear_obs(); salt = 32'h5555_6666; mem_lat = 2;
    queue_cmd(64'hABCD_FFFF_FFC0, 16'd2, 16'h0CC0);
    run_until_idle(200);
    check_int("t4_reqs", obs_req.size(), 2);
    if (obs_req.size() >= 2) begin
      check128("t4_req0", 128'(obs_req[0]), 128'hFFFF_FFC0);
      check128("t4_req1", 128'(obs_req[1]), 128'h0);
    end

    // Zero-length command, then a normal one.
    clear_obs();
    queue_cmd(64'h4000, 16'd0, 16'h0DD0);
    run_until_idle(20);
    repeat (10) step();
    check_int("t5_zero_reqs", req_fires, 0);
    check_int("t5_zero_beats", beats_seen, 0);
    queue_cmd(64'h2000, 16'd1, 16'h0DD1);
    run_until_idle(200);
    check_int("t5_next_beats", beats_seen, 4);

    // Reset after five of sixteen beats, then a stale response in IDLE.
    clear_obs(); salt = 32'h7777_8888; mem_lat = 4;
    queue_cmd(64'h1_0000, 16'd4, 16'h0EE0);
    n = 0;
    while (beats_seen < 5 && n < 300) begin step(); n++; end
    check_int("t6_beats_before_reset", beats_seen, 5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    mem_resp_valid = 1'b1;
    #1 outputs_zero("midreset");
    @(negedge clk);
    outputs_zero("midreset_hold");
    rst_n = 1'b1; mem_resp_valid = 1'b0;
    n = 0;
    while (mem_q.size() > 0 && n < 100) begin step(); n++; end
    check_int("t6_memq_drained", mem_q.size(), 0);
    stale_inject = 1'b1;
    step();
    check1("t6_stale_granted", mem_resp_grant, 1'b1);
    check1("t6_stale_idle", busy, 1'b0);
    stale_inject = 1'b0;
    clear_obs(); salt = 32'h9999_AAAA;
    queue_cmd(64'h3_0040, 16'd3, 16'h0EE1);
    run_until_idle(300);
    check_int("t6_new_beats", beats_seen, 12);

    // Randomized commands, latencies and handshake rates.
    for (int t = 0; t < 40; t++) begin
      salt = $urandom();
      mem_lat = $urandom_range(1, 25);
      req_pct = $urandom_range(30, 100);
      pcie_pct = $urandom_range(30, 100);
      resp_pct = $urandom_range(30, 100);
      queue_cmd({$urandom(), $urandom()}, 16'($urandom_range(0, 12)), 16'($urandom()));
      run_until_idle(5000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
